// File: rtl/cpu_pkg.sv
// Shared opcode/funct3 constants, FSM state type and access-size helper
// used by the MEM/WB stage and its lane-alignment helper.
package cpu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Access width of a load/store; funct3 codes that are not legal for the
  // opcode fall back to a full word access.
  function automatic size_t access_size(input logic is_load, input logic [2:0] f3);
    size_t sz;
    sz = SZ_W;
    if (is_load) begin
      if (f3 == F3_B || f3 == F3_BU)      sz = SZ_B;
      else if (f3 == F3_H || f3 == F3_HU) sz = SZ_H;
    end else begin
      if (f3 == F3_B)      sz = SZ_B;
      else if (f3 == F3_H) sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte enables and replicated write
// data, misalignment detection, and load data alignment down to bit 0.
module lsu_align
  import cpu_pkg::*;
(
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic        o_misalign,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  size_t w_size;

  assign w_size = access_size(i_is_load, i_funct3);

  // Byte enables and alignment check for the requested width
  always_comb begin
    o_we       = 4'b1111;
    o_misalign = 1'b0;
    case (w_size)
      SZ_B: begin
        o_we = 4'b0001 << i_addr_lo;
      end
      SZ_H: begin
        o_we       = 4'b0011 << i_addr_lo;
        o_misalign = i_addr_lo[0];
      end
      default: begin
        o_we       = 4'b1111;
        o_misalign = (i_addr_lo != 2'b00);
      end
    endcase
  end

  // Each byte lane carries the store datum replicated so that whichever
  // lanes are enabled see the correct bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] w_lane;
      always_comb begin
        case (w_size)
          SZ_B:    w_lane = i_store_data[7:0];
          SZ_H:    w_lane = i_store_data[8*(gi%2) +: 8];
          default: w_lane = i_store_data[8*gi +: 8];
        endcase
      end
      assign o_wdata[8*gi +: 8] = w_lane;
    end
  endgenerate

  // Loaded byte/halfword lands at bit 0; extension is the register file's job
  assign o_ld_data = i_rdata >> {i_ld_addr_lo, 3'b000};

endmodule

// File: rtl/mem_wb_unit.sv
// MEM/WB stage: accepts one EX op at a time, runs loads/stores over a
// req/gnt/rvalid data-memory handshake and produces the register-file
// write port (rd, data, strobe, funct3, opcode).
module mem_wb_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [6:0]        ex_opcode,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd_addr,
  input  logic              ex_reg_write,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  output logic              dm_req,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic [4:0]        WB_rd_addr,
  output logic [31:0]       WB_rd_data,
  output logic              RegWrite,
  output logic [2:0]        funct3,
  output logic [6:0]        opcode,
  output logic              misalign,
  output logic              bus_err
);

  state_t            r_state;
  logic              r_is_load;
  logic [ADDR_W+1:0] r_addr;
  logic [3:0]        r_we;
  logic [31:0]       r_wdata;
  logic [4:0]        r_rd;
  logic              r_reg_write;
  logic [2:0]        r_funct3;
  logic [6:0]        r_opcode;
  logic [15:0]       r_cnt;

  logic              w_is_load;
  logic              w_is_mem;
  logic              w_misalign;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ld_data;
  logic [16:0]       w_cnt_inc;
  logic              w_timeout;

  assign w_is_load = (ex_opcode == OPC_LOAD);
  assign w_is_mem  = w_is_load || (ex_opcode == OPC_STORE);
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
  assign w_timeout = (w_cnt_inc >= 17'(TIMEOUT));

  lsu_align u_align (
    .i_is_load    (w_is_load),
    .i_funct3     (ex_funct3),
    .i_addr_lo    (ex_result[1:0]),
    .i_store_data (ex_store_data),
    .i_ld_addr_lo (r_addr[1:0]),
    .i_rdata      (dm_rdata),
    .o_misalign   (w_misalign),
    .o_we         (w_we),
    .o_wdata      (w_wdata),
    .o_ld_data    (w_ld_data)
  );

  // Handshake outputs are decoded straight from the captured access
  assign ex_ready = (r_state == IDLE);
  assign dm_req   = (r_state == REQ);
  assign dm_we    = (r_state == REQ && !r_is_load) ? r_we : 4'b0000;
  assign dm_addr  = r_addr[ADDR_W+1:2];
  assign dm_wdata = r_wdata;

  // Access FSM plus registered write-back port and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_is_load   <= 1'b0;
      r_addr      <= '0;
      r_we        <= 4'b0000;
      r_wdata     <= 32'd0;
      r_rd        <= 5'd0;
      r_reg_write <= 1'b0;
      r_funct3    <= 3'd0;
      r_opcode    <= 7'd0;
      r_cnt       <= 16'd0;
      WB_rd_addr  <= 5'd0;
      WB_rd_data  <= 32'd0;
      RegWrite    <= 1'b0;
      funct3      <= 3'd0;
      opcode      <= 7'd0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ex_valid) begin
            if (!w_is_mem) begin
              RegWrite   <= ex_reg_write;
              WB_rd_addr <= ex_rd_addr;
              WB_rd_data <= ex_result;
              funct3     <= ex_funct3;
              opcode     <= ex_opcode;
            end else if (w_misalign) begin
              misalign <= 1'b1;
            end else begin
              r_is_load   <= w_is_load;
              r_addr      <= ex_result[ADDR_W+1:0];
              r_we        <= w_we;
              r_wdata     <= w_wdata;
              r_rd        <= ex_rd_addr;
              r_reg_write <= ex_reg_write;
              r_funct3    <= ex_funct3;
              r_opcode    <= ex_opcode;
              r_state     <= REQ;
            end
          end
        end
        REQ: begin
          if (dm_gnt) begin
            if (!r_is_load) begin
              r_state <= IDLE;
            end else if (dm_rvalid) begin
              RegWrite   <= r_reg_write;
              WB_rd_addr <= r_rd;
              WB_rd_data <= w_ld_data;
              funct3     <= r_funct3;
              opcode     <= r_opcode;
              r_state    <= IDLE;
            end else begin
              r_cnt   <= 16'd0;
              r_state <= RESP;
            end
          end
        end
        RESP: begin
          if (dm_rvalid) begin
            RegWrite   <= r_reg_write;
            WB_rd_addr <= r_rd;
            WB_rd_data <= w_ld_data;
            funct3     <= r_funct3;
            opcode     <= r_opcode;
            r_cnt      <= 16'd0;
            r_state    <= IDLE;
          end else if (w_timeout) begin
            bus_err <= 1'b1;
            r_cnt   <= 16'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc[15:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
